// File: rtl/mfp_ahb_arbiter_pkg.sv
// mfp_ahb_arbiter_pkg
// Shared constants and types for the two-master AHB-Lite arbiter:
//   - HTRANS encodings
//   - master index constants
//   - default hold limit
//   - grant state type
//   - handover-eligibility helper
package mfp_ahb_arbiter_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic MFP_MASTER_CORE = 1'b0;
  localparam logic MFP_MASTER_AUX  = 1'b1;

  localparam int MFP_MAX_HOLD_DEFAULT = 16;

  typedef enum logic {
    GNT0 = 1'b0,
    GNT1 = 1'b1
  } gnt_state_t;

  // Returns 1 when the transfer type allows the bus to change hands.
  // BUSY and SEQ mean a burst is in flight.
  function automatic logic trans_eligible(input logic [1:0] htrans);
    logic ok;
    case (htrans)
      HTRANS_IDLE:   ok = 1'b1;
      HTRANS_NONSEQ: ok = 1'b1;
      HTRANS_BUSY:   ok = 1'b0;
      HTRANS_SEQ:    ok = 1'b0;
      default:       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mfp_ahb_master_mux.sv
// mfp_ahb_master_mux
// Purely combinational AHB master multiplexer.
//   hmaster        : selects the address-phase signals (haddr..hmastlock).
//   dmaster        : selects the write-data signal (hwdata).
//   m0_* / m1_*    : master 0 / master 1 bus signals.
//   haddr..hwdata  : shared bus outputs.
module mfp_ahb_master_mux
  import mfp_ahb_arbiter_pkg::*;
(
  input  logic        hmaster,
  input  logic        dmaster,
  input  logic [31:0] m0_haddr,
  input  logic [1:0]  m0_htrans,
  input  logic        m0_hwrite,
  input  logic [2:0]  m0_hsize,
  input  logic [2:0]  m0_hburst,
  input  logic [3:0]  m0_hprot,
  input  logic        m0_hmastlock,
  input  logic [31:0] m0_hwdata,
  input  logic [31:0] m1_haddr,
  input  logic [1:0]  m1_htrans,
  input  logic        m1_hwrite,
  input  logic [2:0]  m1_hsize,
  input  logic [2:0]  m1_hburst,
  input  logic [3:0]  m1_hprot,
  input  logic        m1_hmastlock,
  input  logic [31:0] m1_hwdata,
  output logic [31:0] haddr,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [2:0]  hburst,
  output logic [3:0]  hprot,
  output logic        hmastlock,
  output logic [31:0] hwdata
);

  // Address-phase mux: follows the address-phase owner.
  always_comb begin
    haddr     = m0_haddr;
    htrans    = m0_htrans;
    hwrite    = m0_hwrite;
    hsize     = m0_hsize;
    hburst    = m0_hburst;
    hprot     = m0_hprot;
    hmastlock = m0_hmastlock;
    if (hmaster == MFP_MASTER_AUX) begin
      haddr     = m1_haddr;
      htrans    = m1_htrans;
      hwrite    = m1_hwrite;
      hsize     = m1_hsize;
      hburst    = m1_hburst;
      hprot     = m1_hprot;
      hmastlock = m1_hmastlock;
    end else begin
      haddr     = m0_haddr;
      htrans    = m0_htrans;
      hwrite    = m0_hwrite;
      hsize     = m0_hsize;
      hburst    = m0_hburst;
      hprot     = m0_hprot;
      hmastlock = m0_hmastlock;
    end
  end

  // Data-phase mux: follows the data-phase owner, one HREADY behind.
  always_comb begin
    hwdata = m0_hwdata;
    if (dmaster == MFP_MASTER_AUX) begin
      hwdata = m1_hwdata;
    end else begin
      hwdata = m0_hwdata;
    end
  end

endmodule

// File: rtl/mfp_ahb_arbiter.sv
// mfp_ahb_arbiter
// Two-master AHB-Lite arbiter. It does the following:
//   - Grants the shared bus with round-robin tie priority.
//   - Honours HMASTLOCK and never breaks a burst.
//   - Forces a handover after MAX_HOLD contested cycles.
// Ports:
//   HCLK, HRESETn        : bus clock, asynchronous active-low reset.
//   HBUSREQ0/1           : master requests.
//   HGRANT0/1            : one-hot grants.
//   M0_* / M1_*          : per-master AHB signals.
//   HREADY               : slave ready.
//   HADDR..HMASTLOCK     : shared address phase.
//   HWDATA               : shared write data.
//   HMASTER              : address-phase owner index.
module mfp_ahb_arbiter
  import mfp_ahb_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = MFP_MAX_HOLD_DEFAULT
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HBUSREQ0,
  input  logic        HBUSREQ1,
  output logic        HGRANT0,
  output logic        HGRANT1,
  input  logic [31:0] M0_HADDR,
  input  logic [1:0]  M0_HTRANS,
  input  logic        M0_HWRITE,
  input  logic [2:0]  M0_HSIZE,
  input  logic [2:0]  M0_HBURST,
  input  logic [3:0]  M0_HPROT,
  input  logic        M0_HMASTLOCK,
  input  logic [31:0] M0_HWDATA,
  input  logic [31:0] M1_HADDR,
  input  logic [1:0]  M1_HTRANS,
  input  logic        M1_HWRITE,
  input  logic [2:0]  M1_HSIZE,
  input  logic [2:0]  M1_HBURST,
  input  logic [3:0]  M1_HPROT,
  input  logic        M1_HMASTLOCK,
  input  logic [31:0] M1_HWDATA,
  input  logic        HREADY,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  output logic        HMASTER
);

  localparam logic [4:0] HOLD_LIMIT = 5'(MAX_HOLD);

  gnt_state_t  state_r;
  logic        hgrant0_r;
  logic        hgrant1_r;
  logic        hmaster_r;
  logic        dmaster_r;
  logic        rr_r;
  logic [4:0]  hold_cnt_r;

  logic        owner_s;
  logic [1:0]  owner_trans_s;
  logic        owner_lock_s;
  logic        other_req_s;
  logic        handover_s;
  logic        hold_sat_s;
  logic        contest_pick_s;
  logic        pick_s;
  logic        change_s;
  logic [4:0]  hold_next_s;

  assign owner_s    = (state_r == GNT1);
  assign hold_sat_s = (hold_cnt_r >= HOLD_LIMIT);

  // Handover eligibility is judged on the granted master's own signals.
  // A master that has just been granted may already be driving its first transfer.
  always_comb begin
    owner_trans_s = M0_HTRANS;
    owner_lock_s  = M0_HMASTLOCK;
    other_req_s   = HBUSREQ1;
    if (owner_s == MFP_MASTER_AUX) begin
      owner_trans_s = M1_HTRANS;
      owner_lock_s  = M1_HMASTLOCK;
      other_req_s   = HBUSREQ0;
    end else begin
      owner_trans_s = M0_HTRANS;
      owner_lock_s  = M0_HMASTLOCK;
      other_req_s   = HBUSREQ1;
    end
  end

  assign handover_s = HREADY & trans_eligible(owner_trans_s) & ~owner_lock_s;

  // rr always names the non-granted master after a change.
  // Out of reset, rr equals the owner, so a forced contest then goes to the other master.
  assign contest_pick_s = (rr_r != owner_s) ? rr_r : ~owner_s;

  // Next-grant selection. Outside a handover point the owner keeps the bus.
  always_comb begin
    pick_s = owner_s;
    if (handover_s) begin
      case ({HBUSREQ1, HBUSREQ0})
        2'b00:   pick_s = MFP_MASTER_CORE;
        2'b01:   pick_s = MFP_MASTER_CORE;
        2'b10:   pick_s = MFP_MASTER_AUX;
        2'b11: begin
          if (hold_sat_s) begin
            pick_s = contest_pick_s;
          end else begin
            pick_s = owner_s;
          end
        end
        default: pick_s = owner_s;
      endcase
    end else begin
      pick_s = owner_s;
    end
  end

  assign change_s = (pick_s != owner_s);

  // Hold counter: counts contested ownership cycles and saturates at the limit.
  always_comb begin
    hold_next_s = hold_cnt_r;
    if (change_s) begin
      hold_next_s = 5'd0;
    end else if (!other_req_s) begin
      hold_next_s = 5'd0;
    end else if (!hold_sat_s) begin
      hold_next_s = hold_cnt_r + 5'd1;
    end else begin
      hold_next_s = hold_cnt_r;
    end
  end

  // Grant FSM with registered grant, owner-tracking and tie-priority state.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r    <= GNT0;
      hgrant0_r  <= 1'b1;
      hgrant1_r  <= 1'b0;
      hmaster_r  <= MFP_MASTER_CORE;
      dmaster_r  <= MFP_MASTER_CORE;
      rr_r       <= MFP_MASTER_CORE;
      hold_cnt_r <= 5'd0;
    end else begin
      hold_cnt_r <= hold_next_s;
      if (change_s) begin
        state_r   <= pick_s ? GNT1 : GNT0;
        hgrant0_r <= ~pick_s;
        hgrant1_r <= pick_s;
        rr_r      <= owner_s;
      end
      if (HREADY) begin
        hmaster_r <= owner_s;
        dmaster_r <= hmaster_r;
      end
    end
  end

  assign HGRANT0 = hgrant0_r;
  assign HGRANT1 = hgrant1_r;
  assign HMASTER = hmaster_r;

  mfp_ahb_master_mux u_mux (
    .hmaster      (hmaster_r),
    .dmaster      (dmaster_r),
    .m0_haddr     (M0_HADDR),
    .m0_htrans    (M0_HTRANS),
    .m0_hwrite    (M0_HWRITE),
    .m0_hsize     (M0_HSIZE),
    .m0_hburst    (M0_HBURST),
    .m0_hprot     (M0_HPROT),
    .m0_hmastlock (M0_HMASTLOCK),
    .m0_hwdata    (M0_HWDATA),
    .m1_haddr     (M1_HADDR),
    .m1_htrans    (M1_HTRANS),
    .m1_hwrite    (M1_HWRITE),
    .m1_hsize     (M1_HSIZE),
    .m1_hburst    (M1_HBURST),
    .m1_hprot     (M1_HPROT),
    .m1_hmastlock (M1_HMASTLOCK),
    .m1_hwdata    (M1_HWDATA),
    .haddr        (HADDR),
    .htrans       (HTRANS),
    .hwrite       (HWRITE),
    .hsize        (HSIZE),
    .hburst       (HBURST),
    .hprot        (HPROT),
    .hmastlock    (HMASTLOCK),
    .hwdata       (HWDATA)
  );

endmodule

// File: tb/tb_mfp_ahb_arbiter.sv
// tb_mfp_ahb_arbiter
// Directed self-checking bench for mfp_ahb_arbiter. It covers:
//   - reset state
//   - single aux request
//   - contention
//   - lock
//   - burst with wait states
//   - asynchronous reset mid-burst
module tb_mfp_ahb_arbiter;

  logic        HCLK;
  logic        HRESETn;
  logic        HBUSREQ0, HBUSREQ1;
  logic        HGRANT0, HGRANT1;
  logic [31:0] M0_HADDR, M1_HADDR;
  logic [1:0]  M0_HTRANS, M1_HTRANS;
  logic        M0_HWRITE, M1_HWRITE;
  logic [2:0]  M0_HSIZE, M1_HSIZE;
  logic [2:0]  M0_HBURST, M1_HBURST;
  logic [3:0]  M0_HPROT, M1_HPROT;
  logic        M0_HMASTLOCK, M1_HMASTLOCK;
  logic [31:0] M0_HWDATA, M1_HWDATA;
  logic        HREADY;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic        HMASTER;

  int total;
  int bad;

  mfp_ahb_arbiter #(.MAX_HOLD(16)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .HBUSREQ0(HBUSREQ0), .HBUSREQ1(HBUSREQ1),
    .HGRANT0(HGRANT0), .HGRANT1(HGRANT1),
    .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE),
    .M0_HSIZE(M0_HSIZE), .M0_HBURST(M0_HBURST), .M0_HPROT(M0_HPROT),
    .M0_HMASTLOCK(M0_HMASTLOCK), .M0_HWDATA(M0_HWDATA),
    .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE),
    .M1_HSIZE(M1_HSIZE), .M1_HBURST(M1_HBURST), .M1_HPROT(M1_HPROT),
    .M1_HMASTLOCK(M1_HMASTLOCK), .M1_HWDATA(M1_HWDATA),
    .HREADY(HREADY),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
    .HWDATA(HWDATA), .HMASTER(HMASTER)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_inputs();
    HBUSREQ0 = 1'b0;     HBUSREQ1 = 1'b0;     HREADY = 1'b1;
    M0_HADDR = 32'hBF800000; M0_HTRANS = 2'b00; M0_HWRITE = 1'b0;
    M0_HSIZE = 3'b010;   M0_HBURST = 3'b000;  M0_HPROT = 4'h3;
    M0_HMASTLOCK = 1'b0; M0_HWDATA = 32'h00C0FFEE;
    M1_HADDR = 32'h1F800000; M1_HTRANS = 2'b00; M1_HWRITE = 1'b0;
    M1_HSIZE = 3'b010;   M1_HBURST = 3'b000;  M1_HPROT = 4'h1;
    M1_HMASTLOCK = 1'b0; M1_HWDATA = 32'h11111111;
  endtask

  // Reset and leave the bench 1 unit after "edge 0".
  // The next cyc() is then edge 1.
  task automatic do_reset();
    HRESETn = 1'b0;
    cyc();
    cyc();
    HRESETn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nchg;
    int last_chg;
    int bad_int;
    int onehot_err;
    int g1_seen;
    logic prev_g;
    logic first_to;

    total = 0;
    bad   = 0;

    // ---------------- reset with no requests ----------------
    idle_inputs();
    do_reset();
    chk("rst_gnt0", {31'd0, HGRANT0}, 32'd1);
    chk("rst_gnt1", {31'd0, HGRANT1}, 32'd0);
    chk("rst_hmaster", {31'd0, HMASTER}, 32'd0);
    chk("rst_haddr", HADDR, 32'hBF800000);
    chk("rst_hwdata", HWDATA, 32'h00C0FFEE);

    // ---------------- single aux request ----------------
    cyc();
    cyc();
    HBUSREQ1 = 1'b1;                      // sampled at edge 3
    cyc();                                // edge 3
    chk("aux_gnt1_e3", {31'd0, HGRANT1}, 32'd1);
    chk("aux_gnt0_e3", {31'd0, HGRANT0}, 32'd0);
    chk("aux_hm_e3", {31'd0, HMASTER}, 32'd0);
    cyc();                                // edge 4
    chk("aux_hm_e4", {31'd0, HMASTER}, 32'd1);
    M1_HTRANS = 2'b10; M1_HWRITE = 1'b1; M1_HADDR = 32'h1F800000;
    HBUSREQ1 = 1'b0;
    #1;
    chk("aux_haddr", HADDR, 32'h1F800000);
    chk("aux_htrans", {30'd0, HTRANS}, 32'd2);
    chk("aux_hwrite", {31'd0, HWRITE}, 32'd1);
    cyc();                                // edge 5: address accepted
    M1_HTRANS = 2'b00; M1_HWRITE = 1'b0; M1_HWDATA = 32'hDEADBEEF;
    #1;
    chk("aux_hwdata", HWDATA, 32'hDEADBEEF);
    chk("aux_park_gnt0", {31'd0, HGRANT0}, 32'd1);
    cyc();                                // edge 6
    chk("aux_park_hm", {31'd0, HMASTER}, 32'd0);
    chk("aux_park_haddr", HADDR, 32'hBF800000);
    cyc();                                // edge 7
    chk("aux_park_hwdata", HWDATA, 32'h00C0FFEE);

    // ---------------- simultaneous contention ----------------
    idle_inputs();
    HBUSREQ0 = 1'b1; HBUSREQ1 = 1'b1;
    M0_HTRANS = 2'b10; M1_HTRANS = 2'b10;
    do_reset();
    cyc();                                // edge 1
    chk("cont_first_owner", {31'd0, HGRANT0}, 32'd1);
    nchg = 0; last_chg = 1; bad_int = 0; onehot_err = 0;
    prev_g = HGRANT1; first_to = 1'b0;
    for (int e = 2; e <= 80; e++) begin
      cyc();
      if ((HGRANT0 ^ HGRANT1) != 1'b1) onehot_err++;
      if (HGRANT1 != prev_g) begin
        if (nchg == 0) first_to = HGRANT1;
        else if (((e - last_chg) < 16) || ((e - last_chg) > 17)) bad_int++;
        nchg++;
        last_chg = e;
        prev_g = HGRANT1;
      end
    end
    // Changes land at edges 17, 34, 51, 68.
    chk("cont_nchg", 32'(nchg), 32'd4);
    chk("cont_first_to_m1", {31'd0, first_to}, 32'd1);
    chk("cont_interval", 32'(bad_int), 32'd0);
    chk("cont_onehot", 32'(onehot_err), 32'd0);

    // ---------------- lock ----------------
    idle_inputs();
    HBUSREQ0 = 1'b1; HBUSREQ1 = 1'b1;
    M0_HTRANS = 2'b10; M0_HMASTLOCK = 1'b1;
    do_reset();
    g1_seen = 0;
    for (int e = 1; e <= 40; e++) begin
      cyc();
      if (HGRANT1 !== 1'b0) g1_seen++;
    end
    chk("lock_no_change", 32'(g1_seen), 32'd0);
    chk("lock_bus_lock", {31'd0, HMASTLOCK}, 32'd1);
    M0_HMASTLOCK = 1'b0;
    cyc();                                // edge 41
    chk("lock_handover", {31'd0, HGRANT1}, 32'd1);

    // ---------------- burst plus wait states ----------------
    idle_inputs();
    HBUSREQ1 = 1'b1;
    do_reset();
    cyc();                                // edge 1: grant to m1
    HBUSREQ0 = 1'b1;
    g1_seen = 0;
    for (int e = 2; e <= 14; e++) begin
      cyc();
      if (HGRANT1 === 1'b1) g1_seen++;
    end
    chk("burst_pre_hold", 32'(g1_seen), 32'd13);
    M1_HTRANS = 2'b10; M1_HBURST = 3'b011; M1_HWRITE = 1'b1;
    M1_HADDR = 32'h1F800100;
    #1;
    chk("burst_b1_hm", {31'd0, HMASTER}, 32'd1);
    chk("burst_b1_addr", HADDR, 32'h1F800100);
    cyc();                                // edge 15: beat 1 accepted
    M1_HTRANS = 2'b11; M1_HADDR = 32'h1F800104; M1_HWDATA = 32'hA0000000;
    HREADY = 1'b0;
    #1;
    chk("burst_d1", HWDATA, 32'hA0000000);
    cyc();                                // edges 16..18 stalled
    cyc();
    cyc();
    chk("burst_stall_gnt", {31'd0, HGRANT1}, 32'd1);
    chk("burst_stall_d1", HWDATA, 32'hA0000000);
    chk("burst_stall_addr", HADDR, 32'h1F800104);
    HREADY = 1'b1;
    cyc();                                // edge 19: beat 2 accepted
    M1_HADDR = 32'h1F800108; M1_HWDATA = 32'hA0000001;
    #1;
    chk("burst_b2_gnt", {31'd0, HGRANT1}, 32'd1);
    chk("burst_d2", HWDATA, 32'hA0000001);
    cyc();                                // edge 20: beat 3 accepted
    M1_HADDR = 32'h1F80010C; M1_HWDATA = 32'hA0000002;
    #1;
    chk("burst_b3_gnt", {31'd0, HGRANT1}, 32'd1);
    chk("burst_b4_hm", {31'd0, HMASTER}, 32'd1);
    cyc();                                // edge 21: beat 4 accepted
    M1_HTRANS = 2'b00; M1_HWDATA = 32'hA0000003;
    #1;
    chk("burst_b4_gnt", {31'd0, HGRANT1}, 32'd1);
    chk("burst_d4", HWDATA, 32'hA0000003);
    cyc();                                // edge 22: handover
    chk("burst_ho_gnt0", {31'd0, HGRANT0}, 32'd1);
    chk("burst_ho_hm", {31'd0, HMASTER}, 32'd1);
    cyc();                                // edge 23
    chk("burst_ho_hm0", {31'd0, HMASTER}, 32'd0);
    cyc();                                // edge 24
    chk("burst_ho_dm0", HWDATA, 32'h00C0FFEE);

    // ---------------- async reset mid-burst ----------------
    idle_inputs();
    HBUSREQ1 = 1'b1;
    do_reset();
    cyc();                                // edge 1: grant m1
    cyc();                                // edge 2: HMASTER=1
    M1_HTRANS = 2'b10; M1_HBURST = 3'b011; M1_HADDR = 32'h1F800200;
    cyc();                                // edge 3: beat 1 accepted
    M1_HTRANS = 2'b11; M1_HADDR = 32'h1F800204; M1_HWDATA = 32'hB0000000;
    HREADY = 1'b0;
    #1;
    chk("arst_pre_hm", {31'd0, HMASTER}, 32'd1);
    #1;
    HRESETn = 1'b0;
    #1;
    chk("arst_gnt0", {31'd0, HGRANT0}, 32'd1);
    chk("arst_gnt1", {31'd0, HGRANT1}, 32'd0);
    chk("arst_hm", {31'd0, HMASTER}, 32'd0);
    chk("arst_haddr", HADDR, 32'hBF800000);
    chk("arst_hwdata", HWDATA, 32'h00C0FFEE);
    idle_inputs();
    cyc();
    HRESETn = 1'b1;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
